// File: rtl/fphub_pkg.sv
// Shared FPHUB adder constants, the exponent-compare result bundle and the
// shift-saturation helper used by the exponent/alignment stages.
package fphub_pkg;

    localparam int unsigned FPHUB_E    = 8;
    localparam int unsigned FPHUB_M    = 23;
    localparam int unsigned FPHUB_SMAX = FPHUB_M + 3;
    localparam int unsigned FPHUB_SW   = $clog2(FPHUB_M + 4);

    // Result bundle handed to the mantissa swap/align stage.
    typedef struct packed {
        logic [FPHUB_E-1:0]  emax;
        logic                x_ge_y;
        logic                eq;
        logic [FPHUB_SW-1:0] shamt;
        logic                sat;
    } exp_cmp_t;

    function automatic int unsigned sat_shift(input int unsigned mag, input int unsigned smax);
        return (mag > smax) ? smax : mag;
    endfunction

endpackage

// File: rtl/exp_diff_core.sv
// Combinational exponent compare: signed difference -> larger exponent,
// swap control, equality and saturated alignment shift amount.
module exp_diff_core
    import fphub_pkg::*;
#(
    parameter  int unsigned E    = FPHUB_E,
    parameter  int unsigned M    = FPHUB_M,
    localparam int unsigned SMAX = M + 3,
    localparam int unsigned SW   = $clog2(M + 4)
) (
    input  logic [E:0]    dif_i,
    input  logic [E-1:0]  ex_i,
    input  logic [E-1:0]  ey_i,
    output logic [E-1:0]  emax_o,
    output logic          x_ge_y_o,
    output logic          eq_o,
    output logic [SW-1:0] shamt_o,
    output logic          sat_o
);

    logic [E:0]   neg_dif;
    logic [E-1:0] mag;

    // dif spans +/-(2^E-1), so the sign bit alone decides the swap and the
    // negated value always fits back into E bits.
    assign x_ge_y_o = ~dif_i[E];
    assign eq_o     = (dif_i == '0);
    assign neg_dif  = -dif_i;
    assign mag      = x_ge_y_o ? dif_i[E-1:0] : neg_dif[E-1:0];
    assign emax_o   = x_ge_y_o ? ex_i : ey_i;

    assign shamt_o  = SW'(sat_shift(32'(mag), SMAX));
    assign sat_o    = (32'(mag) > SMAX);

endmodule

// File: rtl/exp_diff_pipe.sv
// Two-stage exponent-compare / alignment-amount pipeline with valid/ready
// flow control. Optional out_sat port: define EXP_DIFF_PIPE_SAT_FLAG_EN.
module exp_diff_pipe
    import fphub_pkg::*;
#(
    parameter  int unsigned E     = FPHUB_E,
    parameter  int unsigned M     = FPHUB_M,
    parameter  int unsigned TAG_W = 4,
    localparam int unsigned SW    = $clog2(M + 4)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [E-1:0]     in_ex,
    input  logic [E-1:0]     in_ey,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [E-1:0]     out_emax,
    output logic             out_x_ge_y,
    output logic             out_eq,
    output logic [SW-1:0]    out_shamt,
    output logic [TAG_W-1:0] out_tag
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
    ,
    output logic             out_sat
`endif
);

    // Handshake: a pair transfers on in_valid && in_ready, a result is
    // consumed on out_valid && out_ready. in_ready never looks at in_valid;
    // stage 2 advances when it is empty or being drained, and stage 1 takes
    // a new pair when it is empty or moving forward in the same cycle.
    logic s1_v_q, s1_v_d;
    logic s2_v_q, s2_v_d;
    logic s2_en, accept, consume;

    logic [E:0]       dif_d, dif_q;
    logic [E-1:0]     ex_q, ey_q;
    logic [TAG_W-1:0] tag1_q;

    logic [E-1:0]     emax_d, emax_q;
    logic             x_ge_y_d, x_ge_y_q;
    logic             eq_d, eq_q;
    logic [SW-1:0]    shamt_d, shamt_q;
    logic [TAG_W-1:0] tag2_q;
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
    logic             sat_d, sat_q;
`else
    logic             sat_unused;
`endif

    assign s2_en    = s1_v_q && (!s2_v_q || out_ready);
    assign in_ready = !s1_v_q || s2_en;
    assign accept   = in_valid && in_ready;
    assign consume  = s2_v_q && out_ready;

    assign s1_v_d = accept ? 1'b1 : (s2_en ? 1'b0 : s1_v_q);
    assign s2_v_d = s2_en ? 1'b1 : (consume ? 1'b0 : s2_v_q);
    assign dif_d  = {1'b0, in_ex} - {1'b0, in_ey};

    exp_diff_core #(
        .E (E),
        .M (M)
    ) u_core (
        .dif_i    (dif_q),
        .ex_i     (ex_q),
        .ey_i     (ey_q),
        .emax_o   (emax_d),
        .x_ge_y_o (x_ge_y_d),
        .eq_o     (eq_d),
        .shamt_o  (shamt_d),
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
        .sat_o    (sat_d)
`else
        .sat_o    (sat_unused)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            dif_q  <= '0;
            ex_q   <= '0;
            ey_q   <= '0;
            tag1_q <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            if (accept) begin
                dif_q  <= dif_d;
                ex_q   <= in_ex;
                ey_q   <= in_ey;
                tag1_q <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q   <= 1'b0;
            emax_q   <= '0;
            x_ge_y_q <= 1'b0;
            eq_q     <= 1'b0;
            shamt_q  <= '0;
            tag2_q   <= '0;
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            s2_v_q <= s2_v_d;
            if (s2_en) begin
                emax_q   <= emax_d;
                x_ge_y_q <= x_ge_y_d;
                eq_q     <= eq_d;
                shamt_q  <= shamt_d;
                tag2_q   <= tag1_q;
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
                sat_q    <= sat_d;
`endif
            end
        end
    end

    assign out_valid  = s2_v_q;
    assign out_emax   = emax_q;
    assign out_x_ge_y = x_ge_y_q;
    assign out_eq     = eq_q;
    assign out_shamt  = shamt_q;
    assign out_tag    = tag2_q;
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
    assign out_sat    = sat_q;
`endif

endmodule

// File: tb/tb_exp_diff_pipe.sv
// Bench for exp_diff_pipe: directed literal cases, back-pressure, random
// streaming and mid-stream reset, all scored against a behavioural model.
module tb_exp_diff_pipe;

    localparam int E     = 8;
    localparam int M     = 23;
    localparam int TAG_W = 4;
    localparam int SMAX  = M + 3;
    localparam int SW    = $clog2(M + 4);
    localparam int W     = E + 3 + SW + TAG_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [E-1:0]     in_ex;
    logic [E-1:0]     in_ey;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [E-1:0]     out_emax;
    logic             out_x_ge_y;
    logic             out_eq;
    logic [SW-1:0]    out_shamt;
    logic [TAG_W-1:0] out_tag;
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
    logic             out_sat;
`endif

    exp_diff_pipe #(
        .E     (E),
        .M     (M),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ex      (in_ex),
        .in_ey      (in_ey),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_emax   (out_emax),
        .out_x_ge_y (out_x_ge_y),
        .out_eq     (out_eq),
        .out_shamt  (out_shamt),
        .out_tag    (out_tag)
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
        ,
        .out_sat    (out_sat)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_consumed = 0;
    bit saw_in_ready_low = 0;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] model(input int ex, input int ey, input int tag);
        int mag;
        int sh;
        logic [E-1:0]     emax;
        logic [SW-1:0]    shamt;
        logic [TAG_W-1:0] t;
        mag   = (ex >= ey) ? ex - ey : ey - ex;
        sh    = (mag > SMAX) ? SMAX : mag;
        emax  = E'((ex >= ey) ? ex : ey);
        shamt = SW'(sh);
        t     = TAG_W'(tag);
        return {emax, (ex >= ey), (ex == ey), shamt, (mag > SMAX), t};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    always @(negedge clk) begin
        logic [W-1:0]     f;
        logic [E-1:0]     f_emax;
        logic             f_xge, f_eq, f_sat;
        logic [SW-1:0]    f_sh;
        logic [TAG_W-1:0] f_tag;
        bit               exp_v;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            cyc++;
            exp_v = (exp_q.size() > 0) && (cyc - acc_q[0] >= 2);
            check("out_valid", int'(out_valid), int'(exp_v));
            check("in_ready", int'(in_ready), int'(exp_q.size() < 2 || out_ready));
            if (!in_ready) saw_in_ready_low = 1;
            if (out_valid && exp_q.size() > 0) begin
                f = exp_q[0];
                {f_emax, f_xge, f_eq, f_sh, f_sat, f_tag} = f;
                check("out_emax", int'(out_emax), int'(f_emax));
                check("out_x_ge_y", int'(out_x_ge_y), int'(f_xge));
                check("out_eq", int'(out_eq), int'(f_eq));
                check("out_shamt", int'(out_shamt), int'(f_sh));
                check("out_tag", int'(out_tag), int'(f_tag));
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
                check("out_sat", int'(out_sat), int'(f_sat));
`endif
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    n_consumed++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(in_ex), int'(in_ey), int'(in_tag)));
                acc_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int ex, input int ey, input int tag);
        int  waited;
        bit  ok;
        waited   = 0;
        ok       = 0;
        in_valid = 1'b1;
        in_ex    = E'(ex);
        in_ey    = E'(ey);
        in_tag   = TAG_W'(tag);
        while (!ok && waited < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!ok) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic lit(input int ex, input int ey, input int tag, input int e_emax,
                       input int e_xge, input int e_eq, input int e_sh, input int e_sat);
        int n;
        drain();
        send(ex, ey, tag);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check("lit_valid", int'(out_valid), 1);
        check("lit_emax", int'(out_emax), e_emax);
        check("lit_x_ge_y", int'(out_x_ge_y), e_xge);
        check("lit_eq", int'(out_eq), e_eq);
        check("lit_shamt", int'(out_shamt), e_sh);
        check("lit_tag", int'(out_tag), tag);
`ifdef EXP_DIFF_PIPE_SAT_FLAG_EN
        check("lit_sat", int'(out_sat), e_sat);
`else
        if (e_sat > 1) check("lit_sat_arg", e_sat, 1);
`endif
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        bit done;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ex     = '0;
        in_ey     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_emax", int'(out_emax), 0);
        check("rst_out_shamt", int'(out_shamt), 0);
        check("rst_out_tag", int'(out_tag), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Hand-computed cases
        lit(130, 127, 5, 130, 1, 0, 3, 0);
        lit(100, 100, 6, 100, 1, 1, 0, 0);
        lit(10, 40, 7, 40, 0, 0, 26, 1);
        lit(0, 255, 8, 255, 0, 0, 26, 1);
        lit(255, 0, 9, 255, 1, 0, 26, 1);
        lit(0, 0, 10, 0, 1, 1, 0, 0);
        lit(26, 0, 11, 26, 1, 0, 26, 0);
        lit(0, 27, 12, 27, 0, 0, 26, 1);

        // Back-pressure: out_ready low for relative cycles 3..7
        drain();
        saw_in_ready_low = 0;
        base = n_consumed;
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom_range(0, 255), $urandom_range(0, 255), i);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 7);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        check("bp_in_ready_dropped", int'(saw_in_ready_low), 1);
        check("bp_all_consumed", n_consumed - base, 6);

        // Full throughput
        out_ready = 1'b1;
        base = n_consumed;
        for (int i = 0; i < 100; i++)
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
        drain();
        check("tp_count", n_consumed - base, 100);

        // Random valid gaps and random back-pressure
        done = 0;
        base = n_consumed;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
                end
                done = 1;
            end
            begin
                int n;
                n = 0;
                while (!done && n < 2000) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        drain();
        check("rand_count", n_consumed - base, 80);

        // Reset with two pairs in flight
        out_ready = 1'b0;
        send(200, 3, 1);
        send(4, 90, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_tag", int'(out_tag), 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_stale", int'(out_valid), 0);
        end
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        lit(50, 60, 3, 60, 0, 0, 10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
